// File: rtl/seg7_to_onehot_decoder_if.sv
// seg7_to_onehot_decoder_if: segment bus in, decoded digit out
//   master drives: en (tracking enable), seg[6:0] = {A,B,C,D,E,F,G}, A = bit 6
//   slave drives : onehot[9:0] (D9..D0), bcd[3:0], blank, err, valid (1-cycle pulse)
interface seg7_to_onehot_decoder_if;
    logic       en;
    logic [6:0] seg;
    logic [9:0] onehot;
    logic [3:0] bcd;
    logic       blank;
    logic       err;
    logic       valid;
    modport master (output en, seg, input onehot, bcd, blank, err, valid);
    modport slave  (input en, seg, output onehot, bcd, blank, err, valid);
endinterface

// File: rtl/seg7_to_onehot_decoder.sv
// seg7_to_onehot_decoder: debounces a 7-segment pattern and decodes it to one-hot/BCD
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus     slave side of seg7_to_onehot_decoder_if
//           in : en, seg[6:0]
//           out: onehot[9:0], bcd[3:0] (4'hF if blank/illegal), blank, err, valid
module seg7_to_onehot_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    seg7_to_onehot_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, TRACK, SETTLED} state_t;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [6:0]       seg_q, seg_d, cand_q, cand_d, last_q, last_d;
    logic             last_vld_q, last_vld_d;
    logic [9:0]       onehot_q, onehot_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             blank_q, blank_d, err_q, err_d, valid_q, valid_d;
    logic             commit;
    function automatic logic [3:0] seg_to_bcd(input logic [6:0] p);
        case (p)
            7'b1111110: return 4'd0;
            7'b0110000: return 4'd1;
            7'b1101101: return 4'd2;
            7'b1111001: return 4'd3;
            7'b0110011: return 4'd4;
            7'b1011011: return 4'd5;
            7'b1011111: return 4'd6;
            7'b1110010: return 4'd7;
            7'b1111111: return 4'd8;
            7'b1111011: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction
    always_comb begin
        seg_d      = bus.seg;
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        onehot_d   = onehot_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        commit     = 1'b0;
        cnt_inc    = (cnt_q == STABLE) ? cnt_q : cnt_q + ONE;
        // Dropping enable forgets the last commit so the next settle always reports.
        if (!bus.en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            last_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    cand_d  = seg_q;
                    cnt_d   = ONE;
                end
                TRACK: begin
                    cnt_d  = (seg_q == cand_q) ? cnt_inc : ONE;
                    cand_d = seg_q;
                    commit = (cnt_d == STABLE);
                end
                SETTLED: begin
                    if (seg_q != last_q) begin
                        state_d = TRACK;
                        cand_d  = seg_q;
                        cnt_d   = ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (commit) begin
            state_d = SETTLED;
            // Re-settling on the pattern already shown changes nothing.
            if (!last_vld_q || cand_d != last_q) begin
                last_d     = cand_d;
                last_vld_d = 1'b1;
                bcd_d      = seg_to_bcd(cand_d);
                onehot_d   = (bcd_d == 4'hF) ? 10'd0 : 10'd1 << bcd_d;
                blank_d    = (cand_d == 7'd0);
                err_d      = (bcd_d == 4'hF) && (cand_d != 7'd0);
                valid_d    = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seg_q      <= '0;
            cand_q     <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            onehot_q   <= '0;
            bcd_q      <= 4'hF;
            blank_q    <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_d;
            cand_q     <= cand_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            onehot_q   <= onehot_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end
    assign bus.onehot = onehot_q;
    assign bus.bcd    = bcd_q;
    assign bus.blank  = blank_q;
    assign bus.err    = err_q;
    assign bus.valid  = valid_q;
endmodule

// File: tb/tb_seg7_to_onehot_decoder.sv
// tb_seg7_to_onehot_decoder: randomized + directed check against a sample-window model
module tb_seg7_to_onehot_decoder;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int vcount = 0;
    seg7_to_onehot_decoder_if bus();
    seg7_to_onehot_decoder #(.STABLE_CYCLES(N), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [6:0] tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};
    logic [6:0] m_segq, m_last;
    logic [6:0] win [$];
    bit         m_trk, m_set, m_have;
    logic [9:0] m_onehot;
    logic [3:0] m_bcd;
    logic       m_blank, m_err, m_valid;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int ref_bcd(input logic [6:0] p);
        int b = 15;
        for (int i = 0; i < 10; i++) if (p == tbl[i]) b = i;
        return b;
    endfunction
    function automatic int run_len();
        int k = 0;
        for (int i = win.size() - 1; i >= 0 && win[i] == win[win.size() - 1]; i--) k++;
        return k;
    endfunction
    task automatic model_reset();
        m_segq = '0; m_last = '0; win.delete();
        m_trk = 0; m_set = 0; m_have = 0;
        m_onehot = '0; m_bcd = 4'hF; m_blank = 0; m_err = 0; m_valid = 0;
    endtask
    task automatic model_step(input logic en, input logic [6:0] seg);
        logic [6:0] s = m_segq;
        int b;
        m_segq = seg;
        m_valid = 0;
        if (!en) begin
            m_trk = 0; m_set = 0; m_have = 0; win.delete();
        end else if (!m_trk && !m_set) begin
            m_trk = 1; win.delete(); win.push_back(s);
        end else if (m_set) begin
            if (s != m_last) begin m_set = 0; m_trk = 1; win.delete(); win.push_back(s); end
        end else begin
            win.push_back(s);
            if (run_len() >= N) begin
                m_trk = 0; m_set = 1;
                if (!m_have || s != m_last) begin
                    b = ref_bcd(s);
                    m_have = 1; m_last = s; m_valid = 1;
                    m_bcd = 4'(b);
                    m_onehot = (b == 15) ? 10'd0 : 10'd1 << b;
                    m_blank = (s == 7'd0);
                    m_err = (b == 15) && (s != 7'd0);
                end
            end
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step(bus.en, bus.seg);
        #1;
        chk("onehot", bus.onehot, m_onehot);
        chk("bcd", bus.bcd, m_bcd);
        chk("blank", bus.blank, m_blank);
        chk("err", bus.err, m_err);
        chk("valid", bus.valid, m_valid);
        if (bus.valid === 1'b1) vcount++;
    end
    task automatic hold(input logic e, input logic [6:0] s, input int n);
        bus.en = e;
        bus.seg = s;
        repeat (n) begin @(posedge clk); #2; end
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        chk("rst_onehot", bus.onehot, 10'd0);
        chk("rst_bcd", bus.bcd, 4'hF);
        chk("rst_flags", {bus.blank, bus.err, bus.valid}, 3'b000);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask
    initial begin
        logic [6:0] p;
        model_reset();
        bus.en = 1'b0;
        bus.seg = '0;
        chk("pin_ref_5", ref_bcd(7'b1011011), 5);
        chk("pin_ref_err", ref_bcd(7'b1000000), 15);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_bcd", bus.bcd, 4'hF);
        chk("reset_onehot", bus.onehot, 10'd0);
        hold(1'b1, 7'b0110000, 4);
        chk("t1_edge4_valid", bus.valid, 1'b0);
        hold(1'b1, 7'b0110000, 1);
        chk("t1_edge5_valid", bus.valid, 1'b1);
        chk("t1_onehot", bus.onehot, 10'b0000000010);
        chk("t1_bcd", bus.bcd, 4'd1);
        hold(1'b1, 7'b0110000, 1);
        chk("t1_pulse_len", bus.valid, 1'b0);
        vcount = 0;
        for (int n = 0; n < 10; n++) begin
            hold(1'b1, tbl[n], 8);
            chk("t2_bcd", bus.bcd, n);
            chk("t2_onehot", bus.onehot, 10'd1 << n);
        end
        chk("t2_pulses", vcount, 10);
        hold(1'b1, 7'b1111001, 8);
        vcount = 0;
        hold(1'b1, 7'b1111111, 2);
        hold(1'b1, 7'b1111001, 8);
        chk("t3_glitch_pulses", vcount, 0);
        chk("t3_onehot", bus.onehot, 10'b0000001000);
        hold(1'b1, 7'b1111111, 6);
        chk("t3_d8_pulses", vcount, 1);
        chk("t3_d8_onehot", bus.onehot, 10'b0100000000);
        vcount = 0;
        hold(1'b1, 7'b0000000, 8);
        chk("t4_blank", {bus.blank, bus.err, bus.bcd}, 6'b10_1111);
        chk("t4_blank_onehot", bus.onehot, 10'd0);
        chk("t4_blank_pulses", vcount, 1);
        hold(1'b1, 7'b1000000, 8);
        chk("t4_err", {bus.blank, bus.err, bus.bcd}, 6'b01_1111);
        chk("t4_err_pulses", vcount, 2);
        hold(1'b1, 7'b1011011, 8);
        vcount = 0;
        hold(1'b0, 7'b1011011, 10);
        chk("t5_hold_onehot", bus.onehot, 10'b0000100000);
        chk("t5_idle_pulses", vcount, 0);
        hold(1'b1, 7'b1011011, 5);
        chk("t5_reen_pulses", vcount, 1);
        chk("t5_bcd", bus.bcd, 4'd5);
        hold(1'b1, 7'b1101101, 2);
        pulse_rst();
        vcount = 0;
        hold(1'b1, 7'b1101101, 8);
        chk("t6_track_rst_pulses", vcount, 1);
        chk("t6_bcd", bus.bcd, 4'd2);
        pulse_rst();
        vcount = 0;
        hold(1'b1, 7'b1101101, 4);
        chk("t6_no_early_valid", vcount, 0);
        hold(1'b1, 7'b1101101, 4);
        chk("t6_settled_rst_pulses", vcount, 1);
        p = tbl[0];
        for (int r = 0; r < 150; r++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 5) p = tbl[$urandom_range(0, 9)];
            else if (sel == 5) p = 7'd0;
            else if (sel == 6) p = 7'($urandom);
            hold($urandom_range(0, 11) != 0, p, $urandom_range(1, 8));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
